// File: rtl/sprite_blitter_if.sv
// Sprite blitter bus: draw request, sprite ROM port, frame-buffer write port
// and status.
//   master : drawing client (start/pos, ROM data, frame-buffer ready)
//   slave  : the blitter (ROM address, frame-buffer write, busy/done)
interface sprite_blitter_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();

  logic                  start;
  logic [9:0]            pos_x;
  logic [9:0]            pos_y;
  logic [9:0]            rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;
  logic                  fb_we;
  logic                  fb_ready;
  logic [9:0]            fb_x;
  logic [9:0]            fb_y;
  logic [DATA_WIDTH-1:0] fb_color;
  logic                  busy;
  logic                  done;

  modport master (
    output start, pos_x, pos_y, rom_data, fb_ready,
    input  rom_addr, fb_we, fb_x, fb_y, fb_color, busy, done
  );

  modport slave (
    input  start, pos_x, pos_y, rom_data, fb_ready,
    output rom_addr, fb_we, fb_x, fb_y, fb_color, busy, done
  );

endinterface

// File: rtl/sprite_blitter.sv
// Sprite blitter: copies an SPR_W x SPR_H sprite from a combinational ROM
// into a frame buffer at (pos_x, pos_y), row-major, skipping the transparent
// colour key and pixels that fall off the visible screen.
//   clk   : single clock, rising edge
//   reset : synchronous, active-high
//   bus   : sprite_blitter_if.slave (start/pos in, rom_addr out, rom_data in,
//           fb_we/fb_x/fb_y/fb_color out with fb_ready backpressure,
//           busy/done status out)
module sprite_blitter #(
  parameter int unsigned SPR_W       = 30,
  parameter int unsigned SPR_H       = 30,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] TRANSPARENT = 8'h2b,
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480
) (
  input  logic             clk,
  input  logic             reset,
  sprite_blitter_if.slave  bus
);

  localparam int unsigned COORD_W = 10;
  localparam int unsigned SUM_W   = COORD_W + 1;
  localparam int unsigned COL_W   = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned ROW_W   = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t                 state, state_nx;
  logic [COL_W-1:0]       col, col_nx;
  logic [ROW_W-1:0]       row, row_nx;
  logic [COORD_W-1:0]     org_x, org_x_nx;
  logic [COORD_W-1:0]     org_y, org_y_nx;
  logic                   we, we_nx;
  logic [COORD_W-1:0]     wx, wx_nx;
  logic [COORD_W-1:0]     wy, wy_nx;
  logic [DATA_WIDTH-1:0]  wc, wc_nx;
  logic                   done_q, done_nx;

  logic                   adv;
  logic                   last_col;
  logic                   last_row;
  logic [SUM_W-1:0]       sum_x;
  logic [SUM_W-1:0]       sum_y;
  logic                   onscreen;

  // Screen coordinate of the current pixel, one bit wider so clipping sees
  // positions beyond the 10-bit range.
  assign sum_x    = SUM_W'(org_x) + SUM_W'(col);
  assign sum_y    = SUM_W'(org_y) + SUM_W'(row);
  assign onscreen = (sum_x < SUM_W'(SCREEN_W)) && (sum_y < SUM_W'(SCREEN_H));

  assign last_col = (col == COL_W'(SPR_W - 1));
  assign last_row = (row == ROW_W'(SPR_H - 1));

  // ROM is addressed only while scanning; parked at 0 otherwise.
  assign bus.rom_addr = (state == RUN)
                      ? COORD_W'(32'(row) * SPR_W + 32'(col))
                      : '0;

  assign bus.fb_we    = we;
  assign bus.fb_x     = wx;
  assign bus.fb_y     = wy;
  assign bus.fb_color = wc;
  assign bus.busy     = (state != IDLE);
  assign bus.done     = done_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state, scan counters and output-register next values.
  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    org_x_nx = org_x;
    org_y_nx = org_y;
    we_nx    = we;
    wx_nx    = wx;
    wy_nx    = wy;
    wc_nx    = wc;
    done_nx  = 1'b0;
    adv      = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          org_x_nx = bus.pos_x;
          org_y_nx = bus.pos_y;
          col_nx   = '0;
          row_nx   = '0;
          state_nx = RUN;
        end
      end

      RUN: begin
        // A pending write must be taken before the register is reloaded.
        adv = !we || bus.fb_ready;
        if (adv) begin
          wx_nx = sum_x[COORD_W-1:0];
          wy_nx = sum_y[COORD_W-1:0];
          wc_nx = bus.rom_data;
          we_nx = (bus.rom_data != TRANSPARENT) && onscreen;
          if (last_col) begin
            col_nx = '0;
            if (last_row) begin
              state_nx = DRAIN;
            end else begin
              row_nx = row + ROW_W'(1);
            end
          end else begin
            col_nx = col + COL_W'(1);
          end
        end
      end

      DRAIN: begin
        // Wait for the final pixel (if any) to be accepted, then finish.
        if (!we || bus.fb_ready) begin
          we_nx    = 1'b0;
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      col    <= '0;
      row    <= '0;
      org_x  <= '0;
      org_y  <= '0;
      we     <= 1'b0;
      wx     <= '0;
      wy     <= '0;
      wc     <= '0;
      done_q <= 1'b0;
    end else begin
      col    <= col_nx;
      row    <= row_nx;
      org_x  <= org_x_nx;
      org_y  <= org_y_nx;
      we     <= we_nx;
      wx     <= wx_nx;
      wy     <= wy_nx;
      wc     <= wc_nx;
      done_q <= done_nx;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Testbench for sprite_blitter: scoreboard of expected frame-buffer writes
// built from a pixel-level model of the sprite copy, checked by a monitor
// that pops on every accepted write; draw latency and status checked per draw.
module tb_sprite_blitter;

  localparam int SPR_W = 30;
  localparam int SPR_H = 30;
  localparam int LAT   = 901;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] c;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sprite_blitter_if #(.DATA_WIDTH(8)) bus ();

  sprite_blitter dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  logic [7:0] rom_mem [0:1023];
  assign bus.rom_data = rom_mem[bus.rom_addr];

  wr_t exp_q [$];
  int  total = 0;
  int  bad = 0;
  int  writes = 0;
  int  cyc = 0;
  bit  rand_ready = 1'b0;
  bit  stall_req = 1'b0;
  int  stall_cnt = 0;
  bit  prev_stall = 1'b0;
  logic [28:0] prev_out;

  always @(posedge clk) cyc++;

  // fb_ready driver: steady high, random, or a 5-cycle stall once fb_we is up.
  initial begin
    bus.fb_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_req && bus.fb_we === 1'b1) begin
        stall_req = 1'b0;
        stall_cnt = 5;
      end
      if (stall_cnt > 0) begin
        bus.fb_ready = 1'b0;
        stall_cnt--;
      end else if (rand_ready) begin
        bus.fb_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.fb_ready = 1'b1;
      end
    end
  end

  // Monitor: every accepted write must match the head of the scoreboard;
  // a stalled write must be held unchanged.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        total++;
        if ({bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_color} !== prev_out) begin
          bad++;
          $display("FAIL hold: got %h expected %h", {bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_color}, prev_out);
        end
      end
      if (bus.fb_we === 1'b1 && bus.fb_ready === 1'b1) begin
        writes++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_write: got x=%0d y=%0d c=%h expected none", bus.fb_x, bus.fb_y, bus.fb_color);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          if ({bus.fb_x, bus.fb_y, bus.fb_color} !== e) begin
            bad++;
            $display("FAIL write: got x=%0d y=%0d c=%h expected x=%0d y=%0d c=%h",
                     bus.fb_x, bus.fb_y, bus.fb_color, e.x, e.y, e.c);
          end
        end
      end
      prev_stall = (bus.fb_we === 1'b1 && bus.fb_ready === 1'b0);
      prev_out   = {bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_color};
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ROM contents.
  task automatic fill_stub();
    for (int a = 0; a < 1024; a++) begin
      logic [7:0] v;
      v = 8'(a);
      rom_mem[a] = (v == 8'h2b) ? 8'h00 : v;
    end
  endtask

  // A round sprite: transparent outside a radius-14 disc.
  task automatic fill_real();
    for (int a = 0; a < 1024; a++) rom_mem[a] = 8'h00;
    for (int r = 0; r < SPR_H; r++) begin
      for (int c = 0; c < SPR_W; c++) begin
        int dx;
        int dy;
        logic [7:0] v;
        dx = c - 15;
        dy = r - 15;
        v  = 8'(r * 7 + c * 3);
        if (v == 8'h2b) v = 8'h2c;
        rom_mem[r * SPR_W + c] = (dx * dx + dy * dy > 196) ? 8'h2b : v;
      end
    end
  endtask

  task automatic fill_random();
    for (int a = 0; a < 1024; a++) begin
      rom_mem[a] = ($urandom_range(0, 3) == 0) ? 8'h2b : 8'($urandom);
    end
  endtask

  // Reference: every sprite pixel that is opaque and lands on screen,
  // in row-major order.
  task automatic push_exp(input int px, input int py, output int n);
    n = 0;
    for (int r = 0; r < SPR_H; r++) begin
      for (int c = 0; c < SPR_W; c++) begin
        int x;
        int y;
        logic [7:0] col;
        x   = px + c;
        y   = py + r;
        col = rom_mem[r * SPR_W + c];
        if (col != 8'h2b && x < 640 && y < 480) begin
          exp_q.push_back('{x: 10'(x), y: 10'(y), c: col});
          n++;
        end
      end
    end
  endtask

  // Issues a start; c0 is the cycle number of the start-sampling edge.
  task automatic launch(input int px, input int py, input bit hold, output int c0);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.busy !== 1'b0 && k < 5000);
    if (k >= 5000) check("idle_timeout", 1, 0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.pos_x = 10'(px);
    bus.pos_y = 10'(py);
    @(posedge clk);
    #1;
    c0 = cyc;
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int lat, input bit chk_lat, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.done !== 1'b1 && k < 20000);
    if (k >= 20000) begin
      check({nm, "_done_timeout"}, 1, 0);
    end else begin
      if (chk_lat) check({nm, "_latency"}, cyc - c0, lat);
      check({nm, "_busy_at_done"}, int'(bus.busy), 0);
      @(negedge clk);
      check({nm, "_done_width"}, int'(bus.done), 0);
    end
  endtask

  task automatic draw(input int px, input int py, input bit chk_lat, input int lat, input string nm);
    int n;
    int c0;
    writes = 0;
    push_exp(px, py, n);
    launch(px, py, 1'b0, c0);
    wait_done(c0, lat, chk_lat, nm);
    check({nm, "_writes"}, writes, n);
    check({nm, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    int c0;
    int c1;
    int n;
    bus.start = 1'b0;
    bus.pos_x = '0;
    bus.pos_y = '0;
    fill_stub();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_we", int'(bus.fb_we), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_addr", int'(bus.rom_addr), 0);
    check("rst_x", int'(bus.fb_x), 0);
    check("rst_color", int'(bus.fb_color), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // All-opaque stub sprite, fully on screen.
    fill_stub();
    draw(100, 50, 1'b1, LAT, "stub");

    // Real sprite with transparent border.
    fill_real();
    n = 0;
    for (int a = 0; a < SPR_W * SPR_H; a++) if (rom_mem[a] != 8'h2b) n++;
    draw(0, 0, 1'b1, LAT, "real");
    check("real_opaque_count", writes, n);

    // 5-cycle frame-buffer stall.
    fill_stub();
    writes = 0;
    push_exp(100, 50, n);
    launch(100, 50, 1'b0, c0);
    stall_req = 1'b1;
    wait_done(c0, LAT + 5, 1'b1, "stall");
    check("stall_writes", writes, 900);

    // Clipping at the bottom-right corner.
    draw(620, 470, 1'b1, LAT, "clip");
    check("clip_writes", writes, 200);

    // Reset in the middle of a draw.
    writes = 0;
    push_exp(100, 50, n);
    launch(100, 50, 1'b0, c0);
    repeat (399) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_we", int'(bus.fb_we), 0);
    check("mid_rst_addr", int'(bus.rom_addr), 0);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_no_done", int'(bus.done), 0);
      @(negedge clk);
    end
    draw(0, 0, 1'b1, LAT, "after_rst");

    // start held high across two back-to-back draws.
    writes = 0;
    push_exp(10, 20, n);
    push_exp(10, 20, n);
    launch(10, 20, 1'b1, c0);
    wait_done(c0, LAT, 1'b1, "held1");
    c1 = c0 + LAT + 1;
    check("held_restart_busy", int'(bus.busy), 1);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(c1, LAT, 1'b1, "held2");
    check("held_writes", writes, 1800);
    check("held_left", exp_q.size(), 0);

    // Random sprites and positions, steady then random backpressure.
    fill_random();
    draw(int'($urandom_range(0, 700)), int'($urandom_range(0, 500)), 1'b1, LAT, "rand_lat");
    rand_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fill_random();
      draw(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0, 0, "rand_bp");
    end
    rand_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
